sar_search: RTL and testbench

Successive-approximation search controller for the 4-bit magnitude comparator. It drives the comparator's B operand and En, and samples the Greater/Equal/Less flags, to recover the unknown 4-bit value held on the comparator's A operand. It sits directly around the comparator stage: its outputs feed B and En, and its inputs consume the comparator's flags. It returns the recovered code with a start/busy/done handshake.

---
 rtl/sar_search.sv | 137 +++++++++++++
 tb/tb_sar_search.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
//  Module   : sar_search
//  Purpose  : Successive-approximation controller that recovers the 4-bit A
//             operand of a magnitude comparator by stepping its B operand.
//  Revision : 1.0  initial release
// ============================================================================
module sar_search #(
    parameter int SETTLE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       greater,
    input  logic       equal,
    input  logic       less,
    output logic       cmp_en,
    output logic [3:0] probe,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic [2:0] trials,
    output logic       err
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_TRIAL = 1'b1
    } state_t;

    localparam logic [2:0] c_settle = 3'(SETTLE);

    state_t     r_state;
    logic [3:0] r_w;
    logic [1:0] r_k;
    logic [2:0] r_s;
    logic [3:0] r_probe;
    logic [3:0] r_result;
    logic [2:0] r_trials;
    logic       r_cmp_en;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    logic       w_legal;
    logic [3:0] w_bit;
    logic [3:0] w_w_next;
    logic [3:0] w_next_bit;
    logic [2:0] w_taken;

    // Exactly one flag high: odd parity, but not all three.
    assign w_legal    = (greater ^ equal ^ less) & ~(greater & equal & less);
    assign w_bit      = 4'b0001 << r_k;
    assign w_w_next   = greater ? (r_w | w_bit) : (r_w & ~w_bit);
    assign w_next_bit = 4'b0001 << (r_k - 2'd1);
    assign w_taken    = 3'd4 - {1'b0, r_k};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_w      <= 4'd0;
            r_k      <= 2'd0;
            r_s      <= 3'd0;
            r_probe  <= 4'd0;
            r_result <= 4'd0;
            r_trials <= 3'd0;
            r_cmp_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_TRIAL;
                        r_w      <= 4'd0;
                        r_k      <= 2'd3;
                        r_probe  <= 4'b1000;
                        r_s      <= c_settle;
                        r_err    <= 1'b0;
                        r_trials <= 3'd0;
                        r_busy   <= 1'b1;
                        r_cmp_en <= 1'b1;
                    end
                end
                S_TRIAL: begin
                    if (r_s != 3'd0) begin
                        r_s <= r_s - 3'd1;
                    end else if (!w_legal) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_cmp_en <= 1'b0;
                        r_probe  <= 4'd0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_result <= 4'd0;
                        r_trials <= w_taken;
                    end else if (equal) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_cmp_en <= 1'b0;
                        r_probe  <= 4'd0;
                        r_done   <= 1'b1;
                        r_result <= r_probe;
                        r_trials <= w_taken;
                    end else if (r_k == 2'd0) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_cmp_en <= 1'b0;
                        r_probe  <= 4'd0;
                        r_done   <= 1'b1;
                        r_result <= w_w_next;
                        r_trials <= 3'd4;
                    end else begin
                        // Next probe tries the next lower bit on top of the decided prefix.
                        r_w     <= w_w_next;
                        r_k     <= r_k - 2'd1;
                        r_probe <= w_w_next | w_next_bit;
                        r_s     <= c_settle;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmp_en = r_cmp_en;
    assign probe  = r_probe;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign trials = r_trials;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sar_search.sv
`default_nettype none
// Scoreboard bench for sar_search: two instances (SETTLE 0 and 2), each
// wrapped by a behavioural comparator model holding an unknown A value.
module tb_sar_search;

    localparam int S0 = 0;
    localparam int S1 = 2;

    typedef struct {
        logic [3:0]  result;
        logic [2:0]  trials;
        logic        err;
        logic [15:0] probes;
        int          nprobes;
        int          lat;
        int          gap;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] start;
    logic [1:0] greater;
    logic [1:0] equal;
    logic [1:0] less;
    logic [1:0] cmp_en;
    logic [1:0] busy;
    logic [1:0] done;
    logic [1:0] err;
    logic [3:0] probe  [2];
    logic [3:0] result [2];
    logic [2:0] trials [2];
    logic [3:0] a_val  [2];
    logic [1:0] force_ill;

    int   n_vec;
    int   n_bad;
    int   cyc;
    exp_t q0[$];
    exp_t q1[$];
    int   cnt       [2];
    int   last_done [2];
    logic prev_busy [2];
    logic prev_done [2];

    sar_search #(.SETTLE(S0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .greater(greater[0]), .equal(equal[0]), .less(less[0]),
        .cmp_en(cmp_en[0]), .probe(probe[0]), .busy(busy[0]), .done(done[0]),
        .result(result[0]), .trials(trials[0]), .err(err[0])
    );

    sar_search #(.SETTLE(S1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .greater(greater[1]), .equal(equal[1]), .less(less[1]),
        .cmp_en(cmp_en[1]), .probe(probe[1]), .busy(busy[1]), .done(done[1]),
        .result(result[1]), .trials(trials[1]), .err(err[1])
    );

    // Comparator: Greater is ungated, Equal/Less gated by En; force_ill makes G and L both high.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            greater[i] = force_ill[i] | (a_val[i] > probe[i]);
            less[i]    = force_ill[i] | (cmp_en[i] & (a_val[i] < probe[i]));
            equal[i]   = ~force_ill[i] & cmp_en[i] & (a_val[i] == probe[i]);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int settle_of(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    // Reference: probe for bit k is A's bits above k with bit k set.
    function automatic exp_t model(input int s, input logic [3:0] a, input bit ill);
        exp_t e;
        int   p;
        e.probes  = 16'd0;
        e.nprobes = 0;
        e.gap     = -1;
        if (ill) begin
            e.probes[3:0] = 4'd8;
            e.nprobes     = 1;
            e.err         = 1'b1;
            e.result      = 4'd0;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                p = ((int'(a) >> (k + 1)) << (k + 1)) | (1 << k);
                e.probes[e.nprobes*4 +: 4] = 4'(p);
                e.nprobes++;
                if (p == int'(a)) break;
            end
            e.err    = 1'b0;
            e.result = a;
        end
        e.trials = 3'(e.nprobes);
        e.lat    = e.nprobes * (s + 1);
        return e;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0d required %0d (t=%0t)", name, inst, act, req, $time);
        end
    endtask

    task automatic fail(input string name, input int inst, input string what);
        n_vec++;
        n_bad++;
        $display("FAIL %s inst%0d: %s (t=%0t)", name, inst, what, $time);
    endtask

    task automatic push(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int i, input logic bz, input logic dn, input logic ce,
                       input logic [3:0] pr, input logic [3:0] rs, input logic [2:0] tr,
                       input logic er);
        exp_t e;
        int   idx;
        bit   have;
        have = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (have) e = (i == 0) ? q0[0] : q1[0];
        if (bz) begin
            cnt[i] = prev_busy[i] ? cnt[i] + 1 : 1;
            check("cmp_en_busy", i, ce, 1);
            check("err_clear_busy", i, er, 0);
            check("trials_clear_busy", i, tr, 0);
            if (have) begin
                idx = (cnt[i] - 1) / (settle_of(i) + 1);
                if (idx < e.nprobes) check("probe", i, pr, e.probes[idx*4 +: 4]);
                else fail("probe_overrun", i, $sformatf("got trial %0d required < %0d", idx, e.nprobes));
            end
        end else begin
            check("idle_outputs", i, {ce, pr}, 0);
        end
        if (dn) begin
            if (prev_done[i]) fail("done_width", i, "got done high 2 cycles required 1");
            check("done_not_busy", i, bz, 0);
            if (!have) begin
                fail("unexpected_done", i, "got done=1 required done=0");
            end else begin
                if (i == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                check("result", i, rs, e.result);
                check("trials", i, tr, e.trials);
                check("err", i, er, e.err);
                check("latency", i, cnt[i], e.lat);
                if (e.gap >= 0) check("b2b_gap", i, cyc - last_done[i], e.gap);
            end
            last_done[i] = cyc;
        end
        prev_busy[i] = bz;
        prev_done[i] = dn;
    endtask

    always @(negedge clk) begin
        mon(0, busy[0], done[0], cmp_en[0], probe[0], result[0], trials[0], err[0]);
        mon(1, busy[1], done[1], cmp_en[1], probe[1], result[1], trials[1], err[1]);
    end

    task automatic run_search(input int i, input logic [3:0] a, input bit ill, input bit poke);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy[i] !== 1'b0) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                fail("idle_wait", i, "got busy stuck high required idle");
                return;
            end
        end
        a_val[i]     = a;
        force_ill[i] = ill;
        push(i, model(settle_of(i), a, ill));
        start[i] = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            start[i] = 1'b0;
            if (busy[i] !== 1'b1) break;
            if (poke && $urandom_range(0, 2) == 0) start[i] = 1'b1;
            guard++;
            if (guard > 200) begin
                fail("search_wait", i, "got busy stuck high required completion");
                break;
            end
        end
        start[i]     = 1'b0;
        force_ill[i] = 1'b0;
    endtask

    task automatic hold_start(input int i, input logic [3:0] a, input int n);
        exp_t e;
        int   seen;
        int   guard;
        @(negedge clk);
        while (busy[i] !== 1'b0) @(negedge clk);
        for (int j = 0; j < n; j++) begin
            e     = model(settle_of(i), a, 1'b0);
            e.gap = (j == 0) ? -1 : e.lat + 1;
            push(i, e);
        end
        a_val[i] = a;
        start[i] = 1'b1;
        seen  = 0;
        guard = 0;
        while (seen < n) begin
            @(negedge clk);
            if (done[i]) seen++;
            guard++;
            if (guard > 400) begin
                fail("hold_start_wait", i, $sformatf("got %0d dones required %0d", seen, n));
                break;
            end
        end
        start[i] = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; last_done[i] = 0; prev_busy[i] = 1'b0; prev_done[i] = 1'b0;
            a_val[i] = 4'd0;
        end
        start     = 2'b00;
        force_ill = 2'b00;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", i, busy[i], 0);
            check("rst_done", i, done[i], 0);
            check("rst_cmp_en", i, cmp_en[i], 0);
            check("rst_probe", i, probe[i], 0);
            check("rst_result", i, result[i], 0);
            check("rst_trials", i, trials[i], 0);
            check("rst_err", i, err[i], 0);
        end

        run_search(0, 4'd11, 1'b0, 1'b0);
        run_search(0, 4'd8,  1'b0, 1'b0);
        run_search(0, 4'd0,  1'b0, 1'b0);
        run_search(0, 4'd15, 1'b0, 1'b0);
        run_search(1, 4'd5,  1'b0, 1'b1);
        run_search(0, 4'd6,  1'b1, 1'b0);
        run_search(0, 4'd6,  1'b0, 1'b0);
        run_search(1, 4'd9,  1'b1, 1'b0);
        run_search(1, 4'd9,  1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 2; i++)
                run_search(i, 4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0),
                           ($urandom_range(0, 1) == 1));
        end

        hold_start(0, 4'd8, 4);
        hold_start(0, 4'($urandom_range(1, 15)), 3);
        hold_start(1, 4'($urandom_range(0, 15)), 3);

        // Reset mid-search: no expectation is queued, so any done is a miscompare.
        run_search(0, 4'd11, 1'b0, 1'b0);
        @(negedge clk);
        a_val[0] = 4'd13;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 0, busy[0], 0);
        check("async_rst_cmp_en", 0, cmp_en[0], 0);
        check("async_rst_probe", 0, probe[0], 0);
        check("async_rst_result", 0, result[0], 0);
        check("async_rst_done", 0, done[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no_resume_busy", 0, busy[0], 0);

        run_search(0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("sb_drained", 0, q0.size(), 0);
        check("sb_drained", 1, q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
